// File: rtl/alu_result_stage.sv
// rtl/alu_result_stage.sv - LEGv8 execute-stage result register with NZCV flags, B.cond evaluation and 2-entry skid buffer
module alu_result_stage #(
  parameter int DATA_W = 64,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [3:0]        alu_status,
  input  logic              set_flags,
  input  logic              cond_check,
  input  logic [3:0]        cond,
  input  logic [REG_W-1:0]  rd_in,
  input  logic              wr_en_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [REG_W-1:0]  out_rd,
  output logic              out_wr_en,
  output logic              out_branch_taken,
  output logic [3:0]        flags
);

  localparam int PW = DATA_W + REG_W + 2;

  logic [PW-1:0] out_q, out_d, skid_q, skid_d;
  logic          out_valid_q, out_valid_d;
  logic          skid_valid_q, skid_valid_d;
  logic          in_ready_q, in_ready_d;
  logic [3:0]    flags_q, flags_d;

  logic          accept, xfer;
  logic [3:0]    f;
  logic          fv, fc, fn, fz;
  logic          base, cond_true;
  logic [PW-1:0] beat;

  assign accept = in_valid & in_ready_q;
  assign xfer   = out_valid_q & out_ready;

  // Same-beat forwarding: a flag-setting beat evaluates against its own status.
  assign f = set_flags ? alu_status : flags_q;
  assign {fv, fc, fn, fz} = f;

  // Odd condition codes are the inverse of the preceding even code, except AL.
  always_comb begin
    base = 1'b0;
    case (cond[3:1])
      3'd0: base = fz;
      3'd1: base = fc;
      3'd2: base = fn;
      3'd3: base = fv;
      3'd4: base = fc & ~fz;
      3'd5: base = (fn == fv);
      3'd6: base = ~fz & (fn == fv);
      default: base = 1'b1;
    endcase
    cond_true = (cond[3:1] == 3'd7) ? 1'b1 : (base ^ cond[0]);
  end

  assign beat = {alu_out, rd_in, wr_en_in, cond_check & cond_true};

  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    flags_d      = flags_q;

    if (accept && set_flags) begin
      flags_d = alu_status;
    end

    if (skid_valid_q) begin
      if (xfer) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (!out_valid_q || xfer) begin
        out_d       = beat;
        out_valid_d = 1'b1;
      end else begin
        skid_d       = beat;
        skid_valid_d = 1'b1;
      end
    end else if (xfer) begin
      out_valid_d = 1'b0;
    end

    in_ready_d = ~skid_valid_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b0;
      flags_q      <= 4'b0;
    end else begin
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
      flags_q      <= flags_d;
    end
  end

  assign in_ready                                          = in_ready_q;
  assign out_valid                                         = out_valid_q;
  assign {out_result, out_rd, out_wr_en, out_branch_taken} = out_q;
  assign flags                                             = flags_q;

endmodule
